// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler
// Word sequencer and two-way round-robin arbiter for an 8b/10b transmit path.
// Runs on the bit clock, derives the 10-bit word boundary, frames 72-bit
// payloads as SOF + words + EOF and fills idle time with comma symbols,
// forcing a comma whenever too many strobes have passed without one.
module tx_frame_scheduler #(
  parameter int          WORDS_PER_FRAME = 8,
  parameter int          BITS_PER_WORD   = 10,
  parameter logic [8:0]  IDLE_SYM        = 9'h1BC,
  parameter logic [8:0]  SOF_SYM         = 9'h1FB,
  parameter logic [8:0]  EOF_SYM         = 9'h1FD,
  parameter int          SYNC_PERIOD     = 256
) (
  input  logic                           bitclk,
  input  logic                           rst,
  input  logic [1:0]                     req,
  input  logic [9*WORDS_PER_FRAME-1:0]   frame0,
  input  logic [9*WORDS_PER_FRAME-1:0]   frame1,
  output logic [1:0]                     grant,
  output logic [8:0]                     sym_out,
  output logic                           sym_stb,
  output logic [3:0]                     bit_phase,
  output logic                           busy,
  output logic [15:0]                    frame_cnt
);

  localparam int PW  = 9 * WORDS_PER_FRAME;
  localparam int WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int SCW = $clog2(SYNC_PERIOD + 1);
  localparam logic [3:0]     LAST_PHASE = 4'(BITS_PER_WORD - 1);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(WORDS_PER_FRAME - 1);
  localparam logic [SCW-1:0] SYNC_LIMIT = SCW'(SYNC_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_EOF     = 2'd2
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   shift_r;
  logic [WCW-1:0]  word_cnt_r;
  logic [SCW-1:0]  sync_cnt_r;
  logic            ptr_r;

  logic            boundary_s;
  logic            sync_due_s;
  logic [SCW-1:0]  sync_inc_s;
  logic            win_s;

  assign boundary_s = (bit_phase == LAST_PHASE);
  assign sync_due_s = (sync_cnt_r >= SYNC_LIMIT);
  // Saturating increment: once the limit is reached the count holds there.
  assign sync_inc_s = sync_due_s ? sync_cnt_r : (sync_cnt_r + SCW'(1));

  // Pick the winning channel: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    win_s = 1'b0;
    case (req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ptr_r;
      default: win_s = 1'b0;
    endcase
  end

  // Word phase counter; the wrap from the last phase to 0 is the word boundary.
  always_ff @(posedge bitclk) begin
    if (rst) begin
      bit_phase <= LAST_PHASE;
    end else if (boundary_s) begin
      bit_phase <= 4'd0;
    end else begin
      bit_phase <= bit_phase + 4'd1;
    end
  end

  // Frame FSM with arbitration, payload shifting, sync tracking and registered outputs.
  always_ff @(posedge bitclk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      word_cnt_r <= '0;
      sync_cnt_r <= '0;
      ptr_r      <= 1'b0;
      sym_out    <= IDLE_SYM;
      sym_stb    <= 1'b0;
      grant      <= 2'b00;
      busy       <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      sym_stb <= boundary_s;
      grant   <= 2'b00;
      if (boundary_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!sync_due_s && (req != 2'b00)) begin
              grant      <= win_s ? 2'b10 : 2'b01;
              shift_r    <= win_s ? frame1 : frame0;
              ptr_r      <= ~win_s;
              sym_out    <= SOF_SYM;
              busy       <= 1'b1;
              word_cnt_r <= '0;
              sync_cnt_r <= sync_inc_s;
              state_r    <= ST_PAYLOAD;
            end else begin
              // Idle fill and forced sync share the same comma symbol.
              sym_out    <= IDLE_SYM;
              busy       <= 1'b0;
              sync_cnt_r <= '0;
              state_r    <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            sym_out    <= shift_r[8:0];
            shift_r    <= {9'h000, shift_r[PW-1:9]};
            sync_cnt_r <= sync_inc_s;
            if (word_cnt_r == LAST_WORD) begin
              state_r <= ST_EOF;
            end else begin
              word_cnt_r <= word_cnt_r + WCW'(1);
            end
          end
          ST_EOF: begin
            // busy stays high through the EOF word; IDLE decides whether it drops.
            sym_out    <= EOF_SYM;
            frame_cnt  <= frame_cnt + 16'd1;
            sync_cnt_r <= sync_inc_s;
            state_r    <= ST_IDLE;
          end
          default: begin
            sym_out <= IDLE_SYM;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed self-checking bench for tx_frame_scheduler. A second instance with
// a short sync period exercises forced comma insertion.
module tb_tx_frame_scheduler;

  logic        bitclk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  req16;
  logic [71:0] frame0;
  logic [71:0] frame1;

  logic [1:0]  grant,     grant16;
  logic [8:0]  sym_out,   sym_out16;
  logic        sym_stb,   sym_stb16;
  logic [3:0]  bit_phase, bit_phase16;
  logic        busy,      busy16;
  logic [15:0] frame_cnt, frame_cnt16;

  int n_checks;
  int n_fail;

  tx_frame_scheduler dut (
    .bitclk    (bitclk),
    .rst       (rst),
    .req       (req),
    .frame0    (frame0),
    .frame1    (frame1),
    .grant     (grant),
    .sym_out   (sym_out),
    .sym_stb   (sym_stb),
    .bit_phase (bit_phase),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  tx_frame_scheduler #(.SYNC_PERIOD(16)) dut16 (
    .bitclk    (bitclk),
    .rst       (rst),
    .req       (req16),
    .frame0    (frame0),
    .frame1    (frame1),
    .grant     (grant16),
    .sym_out   (sym_out16),
    .sym_stb   (sym_stb16),
    .bit_phase (bit_phase16),
    .busy      (busy16),
    .frame_cnt (frame_cnt16)
  );

  initial bitclk = 1'b0;
  always #5 bitclk = ~bitclk;

  task automatic tick(input int n);
    repeat (n) @(negedge bitclk);
  endtask

  task automatic do_reset();
    @(negedge bitclk);
    rst   = 1'b1;
    req   = 2'b00;
    req16 = 2'b00;
    @(negedge bitclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic       exp_stb;
    logic [3:0] exp_phase;
    do_reset();
    n_checks++;
    if (sym_out !== 9'h1BC || sym_stb !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 ||
        frame_cnt !== 16'd0 || bit_phase !== 4'd9) begin
      n_fail++;
      $display("FAIL reset_state: sym=%h stb=%b grant=%b busy=%b cnt=%0d phase=%0d, expected 1bc 0 00 0 0 9",
               sym_out, sym_stb, grant, busy, frame_cnt, bit_phase);
    end
    for (int c = 1; c <= 31; c++) begin
      tick(1);
      exp_stb   = ((c % 10) == 1);
      exp_phase = 4'((c - 1) % 10);
      n_checks++;
      if (sym_stb !== exp_stb || bit_phase !== exp_phase) begin
        n_fail++;
        $display("FAIL idle_timing c=%0d: stb=%b phase=%0d, expected stb=%b phase=%0d",
                 c, sym_stb, bit_phase, exp_stb, exp_phase);
      end
      n_checks++;
      if (sym_out !== 9'h1BC || busy !== 1'b0 || grant !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_out c=%0d: sym=%h busy=%b grant=%b, expected 1bc 0 00",
                 c, sym_out, busy, grant);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [8:0] seen [0:11];
    logic [8:0] exp_sym;
    int ns, busy_cnt, grants;
    ns = 0; busy_cnt = 0; grants = 0;
    do_reset();
    req = 2'b01;
    for (int c = 1; c <= 111; c++) begin
      tick(1);
      if (c == 1) begin
        n_checks++;
        if (grant !== 2'b01) begin
          n_fail++;
          $display("FAIL single_grant: grant=%b, expected 01", grant);
        end
        req = 2'b00;
      end
      if (busy === 1'b1) busy_cnt++;
      if (grant !== 2'b00) grants++;
      if (sym_stb === 1'b1) begin
        if (ns < 12) seen[ns] = sym_out;
        ns++;
      end
    end
    n_checks++;
    if (ns != 12) begin
      n_fail++;
      $display("FAIL single_strobes: got %0d strobes, expected 12", ns);
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 0)      exp_sym = 9'h1FB;
      else if (i <= 8) exp_sym = 9'(i);
      else if (i == 9) exp_sym = 9'h1FD;
      else             exp_sym = 9'h1BC;
      n_checks++;
      if (seen[i] !== exp_sym) begin
        n_fail++;
        $display("FAIL single_sym[%0d]: got %h, expected %h", i, seen[i], exp_sym);
      end
    end
    n_checks++;
    if (busy_cnt != 100) begin
      n_fail++;
      $display("FAIL single_busy_len: got %0d cycles, expected 100", busy_cnt);
    end
    n_checks++;
    if (grants != 1) begin
      n_fail++;
      $display("FAIL single_grant_count: got %0d, expected 1", grants);
    end
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_frame_cnt: got %0d, expected 1", frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int s, f, pos;
    logic [8:0] exp_sym;
    logic [1:0] exp_gnt;
    s = 0;
    do_reset();
    req = 2'b11;
    for (int c = 1; c <= 400; c++) begin
      tick(1);
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_busy c=%0d: busy=%b, expected 1", c, busy);
      end
      if (sym_stb === 1'b1) begin
        f   = s / 10;
        pos = s % 10;
        if (pos == 0)      exp_sym = 9'h1FB;
        else if (pos == 9) exp_sym = 9'h1FD;
        else               exp_sym = ((f % 2) == 1) ? (9'h100 + 9'(pos)) : 9'(pos);
        if (pos == 0) exp_gnt = ((f % 2) == 1) ? 2'b10 : 2'b01;
        else          exp_gnt = 2'b00;
        n_checks++;
        if (sym_out !== exp_sym || grant !== exp_gnt) begin
          n_fail++;
          $display("FAIL b2b_sym s=%0d: sym=%h grant=%b, expected %h %b",
                   s, sym_out, grant, exp_sym, exp_gnt);
        end
        s++;
      end
    end
    req = 2'b00;
    n_checks++;
    if (s != 40 || frame_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL b2b_count: strobes=%0d frame_cnt=%0d, expected 40 4", s, frame_cnt);
    end
    tick(10);
    n_checks++;
    if (sym_out !== 9'h1BC || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_tail: sym=%h busy=%b, expected 1bc 0", sym_out, busy);
    end
  endtask

  task automatic test_sync();
    int s, p, pos;
    logic [8:0] exp_sym;
    s = 0;
    do_reset();
    req16 = 2'b01;
    for (int c = 1; c <= 420; c++) begin
      tick(1);
      if (sym_stb16 === 1'b1) begin
        p   = s % 21;
        pos = p % 10;
        if (p == 20)       exp_sym = 9'h1BC;
        else if (pos == 0) exp_sym = 9'h1FB;
        else if (pos == 9) exp_sym = 9'h1FD;
        else               exp_sym = 9'(pos);
        n_checks++;
        if (sym_out16 !== exp_sym) begin
          n_fail++;
          $display("FAIL sync_sym s=%0d: got %h, expected %h", s, sym_out16, exp_sym);
        end
        s++;
      end
    end
    req16 = 2'b00;
    n_checks++;
    if (s != 42 || frame_cnt16 !== 16'd4) begin
      n_fail++;
      $display("FAIL sync_count: strobes=%0d frame_cnt=%0d, expected 42 4", s, frame_cnt16);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    req = 2'b10;
    tick(1);
    n_checks++;
    if (grant !== 2'b10 || sym_out !== 9'h1FB) begin
      n_fail++;
      $display("FAIL mid_first_sof: grant=%b sym=%h, expected 10 1fb", grant, sym_out);
    end
    tick(44);
    n_checks++;
    if (sym_out !== 9'h104) begin
      n_fail++;
      $display("FAIL mid_word4: got %h, expected 104", sym_out);
    end
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (sym_out !== 9'h1BC || sym_stb !== 1'b0 || busy !== 1'b0 || grant !== 2'b00 ||
        frame_cnt !== 16'd0 || bit_phase !== 4'd9) begin
      n_fail++;
      $display("FAIL mid_reset_state: sym=%h stb=%b busy=%b grant=%b cnt=%0d phase=%0d, expected 1bc 0 0 00 0 9",
               sym_out, sym_stb, busy, grant, frame_cnt, bit_phase);
    end
    rst = 1'b0;
    tick(1);
    n_checks++;
    if (sym_stb !== 1'b1 || sym_out !== 9'h1FB || grant !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_regrant: stb=%b sym=%h grant=%b, expected 1 1fb 10", sym_stb, sym_out, grant);
    end
    req = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick(10);
      n_checks++;
      if (sym_out !== (9'h100 + 9'(k))) begin
        n_fail++;
        $display("FAIL mid_word%0d: got %h, expected %h", k, sym_out, 9'h100 + 9'(k));
      end
    end
    tick(10);
    n_checks++;
    if (sym_out !== 9'h1FD || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_eof: sym=%h cnt=%0d, expected 1fd 1", sym_out, frame_cnt);
    end
  endtask

  task automatic test_req_latency();
    int  grants, n;
    bit  got;
    grants = 0; n = 0; got = 1'b0;
    do_reset();
    tick(1);
    tick(3);
    n_checks++;
    if (bit_phase !== 4'd3) begin
      n_fail++;
      $display("FAIL lat_phase3: got %0d, expected 3", bit_phase);
    end
    req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (grant !== 2'b00) grants++;
    end
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (grant !== 2'b00) grants++;
    end
    n_checks++;
    if (sym_stb !== 1'b1 || sym_out !== 9'h1BC || grants != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_pulse_ignored: stb=%b sym=%h grants=%0d busy=%b, expected 1 1bc 0 0",
               sym_stb, sym_out, grants, busy);
    end
    tick(5);
    req = 2'b01;
    for (int i = 0; i < 12 && !got; i++) begin
      tick(1);
      n = i + 1;
      if (sym_stb === 1'b1) got = 1'b1;
      else if (grant !== 2'b00) grants++;
    end
    n_checks++;
    if (!got || n != 5 || grant !== 2'b01 || sym_out !== 9'h1FB || grants != 0) begin
      n_fail++;
      $display("FAIL lat_grant: got=%b ticks=%0d grant=%b sym=%h early=%0d, expected 1 5 01 1fb 0",
               got, n, grant, sym_out, grants);
    end
    req = 2'b00;
    tick(90);
    n_checks++;
    if (sym_out !== 9'h1FD || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL lat_eof: sym=%h cnt=%0d, expected 1fd 1", sym_out, frame_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = 2'b00;
    req16    = 2'b00;
    for (int k = 0; k < 8; k++) begin
      frame0[9*k +: 9] = 9'(k + 1);
      frame1[9*k +: 9] = 9'h100 + 9'(k + 1);
    end
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_sync();
    test_reset_mid_frame();
    test_req_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
